accel_slave_regs: RTL and testbench
===================================

// Module: accel_slave_regs
// PURPOSE
//  Parametrised bus-slave register block for the multiplier/adder accelerator.
//  Decodes single-cycle slave accesses into operand-FIFO writes, start and clear pulses, and result/status reads.
//  Replaces the fixed 32-bit, depth-8 slave with configurable width, depth and address base.
//  Adds a sticky, write-1-to-clear interrupt and a registered read path.
// PARAMETERS
//  DATA_W      32    data bus, operand and result width
//  ADDR_W      8     slave address width
//  BASE        0     register-map base address (offsets below are added to it)
//  FIFO_DEPTH  8     operand FIFO depth; a write is accepted while count < FIFO_DEPTH
//  CNT_W       4     FIFO data-count width, equal to $clog2(FIFO_DEPTH)+1
//  RADDR_W     3     result-buffer read-address width
// PORTS
//  clk          in   1        clock, rising edge
//  reset        in   1        asynchronous reset, active-high
//  s_sel        in   1        slave select
//  s_wr         in   1        1 = write, 0 = read (qualified by s_sel)
//  s_addr       in   ADDR_W   register address
//  s_din        in   DATA_W   write data
//  s_dout       out  DATA_W   read data, registered
//  mc_wdata     out  DATA_W   multiplicand FIFO write data
//  mc_we        out  1        multiplicand FIFO write enable
//  mp_wdata     out  DATA_W   multiplier FIFO write data
//  mp_we        out  1        multiplier FIFO write enable
//  mc_count     in   CNT_W    multiplicand FIFO data count
//  mp_count     in   CNT_W    multiplier FIFO data count
//  mul_start    out  1        multiply start, 1-cycle pulse
//  add_start    out  1        adder start, 1-cycle pulse
//  op_clear     out  1        core clear, 1-cycle pulse
//  op_done      in   1        adder done, level
//  result       in   DATA_W   result buffer data at r_addr
//  r_addr       out  RADDR_W  result buffer read address
//  m_interrupt  out  1        interrupt to master, level, registered
// BEHAVIOUR
//  Reset:
//   - clk and a single asynchronous, active-high reset; all flops reset asynchronously.
//   - Every output resets to 0; the int_en, int_pend and err_cnt registers also reset to 0.
//  Access: an access occurs when s_sel=1; s_wr selects write or read.
//  Register map (offsets from BASE):
//   - 0 MC_DATA W: push s_din to the multiplicand FIFO.
//   - 1 MP_DATA W: push s_din to the multiplier FIFO.
//   - 2 INT_EN RW: bit0 only.
//   - 3 MUL_START W: pulse when bit0=1.
//   - 4 ADD_START W: pulse when bit0=1.
//   - 5 CLEAR W: pulse when bit0=1.
//   - 6 RESULT R: read result, then r_addr increments.
//   - 7 STATUS R: {.., op_done, int_pend, mc_count, mp_count}, zero-extended.
//   - 8 INT_PEND W1C: writing bit0=1 clears int_pend.
//   - 9 ERR_CNT R: see CONFIGURATION.
//  Unmapped accesses: writes are ignored; reads return 0.
//  Write path:
//   - All write side effects are registered: a pulse or FIFO write appears the cycle after the access.
//   - mc_wdata/mp_wdata hold the captured s_din in that same cycle.
//  FIFO full: a write is dropped when count >= FIFO_DEPTH. No back-pressure is given on the bus.
//  Read path:
//   - s_dout updates the cycle after a read access and holds its value otherwise.
//   - A RESULT read samples the current r_addr and increments it with the same edge.
//   - r_addr wraps from 2^RADDR_W-1 to 0.
//  Interrupt:
//   - int_pend is set on a rising edge of op_done (one registered op_done stage).
//   - It stays set until a W1C write or op_clear.
//   - If set and clear occur in the same cycle, set wins.
//   - m_interrupt = int_en & int_pend, registered: it rises 2 cycles after op_done rises.
//  op_clear pulse: in the pulse cycle, r_addr <= 0 and int_pend <= 0. int_en is unchanged.
//  Reset mid-operation: all state is lost immediately and no pulse is emitted.
// CONFIGURATION
//  ACCEL_SLAVE_ERRCNT_EN:
//   - Defined: an 8-bit err_cnt increments, saturating at 255, on each dropped FIFO write.
//     It is readable at offset 9 and cleared by op_clear.
//   - Undefined: no counter is built; offset 9 reads 0.
// STRUCTURE
//  Package accel_pkg:
//   - register offset localparams (OFF_MC..OFF_ERR);
//   - STATUS bit-position constants;
//   - access-type enum {ACC_NONE, ACC_RD, ACC_WR}.
//  One sub-module, accel_irq_ctrl: edge detect, sticky pending, W1C and enable gating.
//  Decode and the read mux stay in the top.
// TESTING
//  - Reset: assert reset mid-burst -> all outputs 0 asynchronously; r_addr=0, m_interrupt=0.
//  - Write MC_DATA 0x1234_5678 with mc_count=3 -> next cycle mc_we=1, mc_wdata=0x1234_5678.
//    Repeat with mc_count=8 -> mc_we=0 and err_cnt=1 when the EN macro is defined.
//  - Write 1 to offset 3 -> mul_start high exactly 1 cycle; writing 0 gives no pulse.
//  - 9 reads of RESULT -> r_addr sequence 0..7,0.
//    s_dout equals result at the sampled r_addr one cycle after each read.
//  - INT_EN=1, raise op_done -> m_interrupt=1 two cycles later.
//    W1C in the same cycle as a new op_done edge -> int_pend stays 1.
//  - CLEAR pulse with int_pend=1 and r_addr=5 -> both 0 after the pulse; INT_EN remains 1.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared register map, STATUS layout and access-type encoding for the accelerator slave.
package accel_pkg;

    localparam int OFF_MC     = 0;
    localparam int OFF_MP     = 1;
    localparam int OFF_INT_EN = 2;
    localparam int OFF_MUL    = 3;
    localparam int OFF_ADD    = 4;
    localparam int OFF_CLR    = 5;
    localparam int OFF_RES    = 6;
    localparam int OFF_STAT   = 7;
    localparam int OFF_PEND   = 8;
    localparam int OFF_ERR    = 9;
    localparam int NUM_REGS   = 10;

    // STATUS: count fields are CNT_W wide each; flag bits sit directly above both count fields.
    localparam int ST_MP_FIELD = 0;
    localparam int ST_MC_FIELD = 1;
    localparam int ST_PEND_REL = 0;
    localparam int ST_DONE_REL = 1;

    localparam int ERR_W = 8;

    typedef enum logic [1:0] {
        ACC_NONE = 2'd0,
        ACC_RD   = 2'd1,
        ACC_WR   = 2'd2
    } acc_e;

endpackage

// File: rtl/accel_irq_ctrl.sv
// Interrupt controller: op_done rising-edge detect, sticky pending flag with W1C/clear,
// and registered enable gating of the master interrupt.
module accel_irq_ctrl (
    input  logic clk,
    input  logic reset,
    input  logic op_done_i,
    input  logic w1c_i,
    input  logic clr_i,
    input  logic int_en_i,
    output logic int_pend_o,
    output logic m_interrupt_o
);

    logic done_q;
    logic pend_q;
    logic pend_d;
    logic irq_q;

    // A new op_done edge outranks a simultaneous W1C or core clear.
    always_comb begin
        pend_d = pend_q;
        if (op_done_i && !done_q) begin
            pend_d = 1'b1;
        end else if (w1c_i || clr_i) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q <= 1'b0;
            pend_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            done_q <= op_done_i;
            pend_q <= pend_d;
            irq_q  <= int_en_i & pend_q;
        end
    end

    assign int_pend_o    = pend_q;
    assign m_interrupt_o = irq_q;

endmodule

// File: rtl/accel_slave_regs.sv
// Bus-slave register block for the multiplier/adder accelerator.
// Optional build macro ACCEL_SLAVE_ERRCNT_EN adds a saturating dropped-write counter at offset 9.
module accel_slave_regs
    import accel_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 8,
    parameter int BASE       = 0,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 4,
    parameter int RADDR_W    = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               s_sel,
    input  logic               s_wr,
    input  logic [ADDR_W-1:0]  s_addr,
    input  logic [DATA_W-1:0]  s_din,
    output logic [DATA_W-1:0]  s_dout,
    output logic [DATA_W-1:0]  mc_wdata,
    output logic               mc_we,
    output logic [DATA_W-1:0]  mp_wdata,
    output logic               mp_we,
    input  logic [CNT_W-1:0]   mc_count,
    input  logic [CNT_W-1:0]   mp_count,
    output logic               mul_start,
    output logic               add_start,
    output logic               op_clear,
    input  logic               op_done,
    input  logic [DATA_W-1:0]  result,
    output logic [RADDR_W-1:0] r_addr,
    output logic               m_interrupt
);

    localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(BASE);
    localparam logic [CNT_W-1:0]  DepthCnt = CNT_W'(FIFO_DEPTH);

    function automatic logic atOff(input logic [ADDR_W-1:0] a, input int o);
        return a == ADDR_W'(o);
    endfunction

    acc_e              acc;
    logic [ADDR_W-1:0] off;
    logic              hit;
    logic              wrHit;
    logic              rdHit;

    always_comb begin
        acc = ACC_NONE;
        if (s_sel) begin
            acc = s_wr ? ACC_WR : ACC_RD;
        end
        off   = s_addr - BaseAddr;
        hit   = (s_addr >= BaseAddr) && (off < ADDR_W'(NUM_REGS));
        wrHit = (acc == ACC_WR) && hit;
        rdHit = (acc == ACC_RD) && hit;
    end

    logic wrMc, wrMp, mcAccept, mpAccept, rdRes, w1c;
    assign wrMc     = wrHit && atOff(off, OFF_MC);
    assign wrMp     = wrHit && atOff(off, OFF_MP);
    assign mcAccept = wrMc && (mc_count < DepthCnt);
    assign mpAccept = wrMp && (mp_count < DepthCnt);
    assign rdRes    = rdHit && atOff(off, OFF_RES);
    assign w1c      = wrHit && atOff(off, OFF_PEND) && s_din[0];

    logic [DATA_W-1:0]  s_dout_q, s_dout_d;
    logic [DATA_W-1:0]  mc_wdata_q, mc_wdata_d;
    logic [DATA_W-1:0]  mp_wdata_q, mp_wdata_d;
    logic               mc_we_q, mp_we_q;
    logic               mul_q, add_q, clr_q;
    logic               int_en_q, int_en_d;
    logic [RADDR_W-1:0] r_addr_q, r_addr_d;
    logic               int_pend;
    logic [DATA_W-1:0]  errRead;

`ifdef ACCEL_SLAVE_ERRCNT_EN
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic             dropWr;

    assign dropWr = (wrMc && !mcAccept) || (wrMp && !mpAccept);

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (clr_q) begin
            err_cnt_d = '0;
        end else if (dropWr && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign errRead = DATA_W'(err_cnt_q);
`else
    assign errRead = '0;
`endif

    // Read mux: write-only and unmapped offsets read as zero.
    logic [DATA_W-1:0] statusWord;
    logic [DATA_W-1:0] rdData;

    always_comb begin
        statusWord = '0;
        statusWord[ST_MP_FIELD*CNT_W +: CNT_W] = mp_count;
        statusWord[ST_MC_FIELD*CNT_W +: CNT_W] = mc_count;
        statusWord[2*CNT_W + ST_PEND_REL]      = int_pend;
        statusWord[2*CNT_W + ST_DONE_REL]      = op_done;

        rdData = '0;
        if (hit) begin
            case (off)
                ADDR_W'(OFF_INT_EN): rdData = DATA_W'(int_en_q);
                ADDR_W'(OFF_RES):    rdData = result;
                ADDR_W'(OFF_STAT):   rdData = statusWord;
                ADDR_W'(OFF_ERR):    rdData = errRead;
                default:             rdData = '0;
            endcase
        end
    end

    // A core clear pulse rewinds the result pointer even if a RESULT read lands in the same cycle.
    always_comb begin
        s_dout_d   = s_dout_q;
        mc_wdata_d = mc_wdata_q;
        mp_wdata_d = mp_wdata_q;
        int_en_d   = int_en_q;
        r_addr_d   = r_addr_q;

        if (acc == ACC_RD) begin
            s_dout_d = rdData;
        end
        if (mcAccept) begin
            mc_wdata_d = s_din;
        end
        if (mpAccept) begin
            mp_wdata_d = s_din;
        end
        if (wrHit && atOff(off, OFF_INT_EN)) begin
            int_en_d = s_din[0];
        end
        if (clr_q) begin
            r_addr_d = '0;
        end else if (rdRes) begin
            r_addr_d = r_addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_dout_q   <= '0;
            mc_wdata_q <= '0;
            mp_wdata_q <= '0;
            mc_we_q    <= 1'b0;
            mp_we_q    <= 1'b0;
            mul_q      <= 1'b0;
            add_q      <= 1'b0;
            clr_q      <= 1'b0;
            int_en_q   <= 1'b0;
            r_addr_q   <= '0;
        end else begin
            s_dout_q   <= s_dout_d;
            mc_wdata_q <= mc_wdata_d;
            mp_wdata_q <= mp_wdata_d;
            mc_we_q    <= mcAccept;
            mp_we_q    <= mpAccept;
            mul_q      <= wrHit && atOff(off, OFF_MUL) && s_din[0];
            add_q      <= wrHit && atOff(off, OFF_ADD) && s_din[0];
            clr_q      <= wrHit && atOff(off, OFF_CLR) && s_din[0];
            int_en_q   <= int_en_d;
            r_addr_q   <= r_addr_d;
        end
    end

    accel_irq_ctrl u_irq (
        .clk           (clk),
        .reset         (reset),
        .op_done_i     (op_done),
        .w1c_i         (w1c),
        .clr_i         (clr_q),
        .int_en_i      (int_en_q),
        .int_pend_o    (int_pend),
        .m_interrupt_o (m_interrupt)
    );

    assign s_dout    = s_dout_q;
    assign mc_wdata  = mc_wdata_q;
    assign mp_wdata  = mp_wdata_q;
    assign mc_we     = mc_we_q;
    assign mp_we     = mp_we_q;
    assign mul_start = mul_q;
    assign add_start = add_q;
    assign op_clear  = clr_q;
    assign r_addr    = r_addr_q;

endmodule

// File: tb/tb_accel_slave_regs.sv
// Self-checking bench for accel_slave_regs: directed scenarios plus randomized bus traffic
// checked every cycle against a register-map-level reference model.
module tb_accel_slave_regs;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 8;
    localparam int BASE       = 16;
    localparam int FIFO_DEPTH = 8;
    localparam int CNT_W      = 4;
    localparam int RADDR_W    = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               s_sel, s_wr;
    logic [ADDR_W-1:0]  s_addr;
    logic [DATA_W-1:0]  s_din, s_dout;
    logic [DATA_W-1:0]  mc_wdata, mp_wdata;
    logic               mc_we, mp_we;
    logic [CNT_W-1:0]   mc_count, mp_count;
    logic               mul_start, add_start, op_clear, op_done;
    logic [DATA_W-1:0]  result;
    logic [RADDR_W-1:0] r_addr;
    logic               m_interrupt;

    logic [DATA_W-1:0] resBuf [0:7];
    assign result = resBuf[r_addr];

    always #5 clk = ~clk;

    accel_slave_regs #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .BASE(BASE),
        .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W), .RADDR_W(RADDR_W)
    ) dut (
        .clk(clk), .reset(reset),
        .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout),
        .mc_wdata(mc_wdata), .mc_we(mc_we), .mp_wdata(mp_wdata), .mp_we(mp_we),
        .mc_count(mc_count), .mp_count(mp_count),
        .mul_start(mul_start), .add_start(add_start), .op_clear(op_clear),
        .op_done(op_done), .result(result), .r_addr(r_addr), .m_interrupt(m_interrupt)
    );

    int compared   = 0;
    int mismatched = 0;

    // Expected outputs plus the architectural state the register map describes.
    logic [31:0] eDout, eMcWdata, eMpWdata;
    bit          eMcWe, eMpWe, eMul, eAdd, eClr, eInt;
    int          eRaddr;
    bit          mPend, mIntEn, mDonePrev;
    int          mErr;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        eDout = 0; eMcWdata = 0; eMpWdata = 0;
        eMcWe = 0; eMpWe = 0; eMul = 0; eAdd = 0; eClr = 0; eInt = 0;
        eRaddr = 0; mPend = 0; mIntEn = 0; mDonePrev = 0; mErr = 0;
    endtask

    task automatic checkAll(input string tag);
        checkOutput({tag, ".s_dout"},      s_dout,      eDout);
        checkOutput({tag, ".mc_we"},       mc_we,       eMcWe);
        checkOutput({tag, ".mc_wdata"},    mc_wdata,    eMcWdata);
        checkOutput({tag, ".mp_we"},       mp_we,       eMpWe);
        checkOutput({tag, ".mp_wdata"},    mp_wdata,    eMpWdata);
        checkOutput({tag, ".mul_start"},   mul_start,   eMul);
        checkOutput({tag, ".add_start"},   add_start,   eAdd);
        checkOutput({tag, ".op_clear"},    op_clear,    eClr);
        checkOutput({tag, ".r_addr"},      r_addr,      eRaddr);
        checkOutput({tag, ".m_interrupt"}, m_interrupt, eInt);
    endtask

    // Drives one bus cycle (offset relative to BASE; outside 0..9 is unmapped), advances the
    // reference model by one clock and compares every output just after the edge.
    task automatic applyStimulus(input bit sel, input bit wr, input int off, input logic [31:0] din,
                                 input int mcC, input int mpC, input bit done, input string tag);
        bit          isRd, isWr, clrNow, rise, drop;
        logic [31:0] rdVal;
        int          nRaddr;
        bit          nPend;

        s_sel = sel; s_wr = wr; s_addr = ADDR_W'(BASE + off); s_din = din;
        mc_count = CNT_W'(mcC); mp_count = CNT_W'(mpC); op_done = done;

        isRd   = sel && !wr;
        isWr   = sel && wr;
        clrNow = eClr;

        rdVal = 0;
        case (off)
            2: rdVal = 32'(mIntEn);
            6: rdVal = resBuf[eRaddr];
            7: rdVal = (done ? 32'd512 : 32'd0) + (mPend ? 32'd256 : 32'd0) + 32'(mcC * 16 + mpC);
`ifdef ACCEL_SLAVE_ERRCNT_EN
            9: rdVal = 32'(mErr);
`endif
            default: rdVal = 0;
        endcase
        if (isRd) eDout = rdVal;

        eMcWe = isWr && off == 0 && mcC < FIFO_DEPTH;
        eMpWe = isWr && off == 1 && mpC < FIFO_DEPTH;
        if (eMcWe) eMcWdata = din;
        if (eMpWe) eMpWdata = din;
        drop = isWr && ((off == 0 && mcC >= FIFO_DEPTH) || (off == 1 && mpC >= FIFO_DEPTH));

        eMul = isWr && off == 3 && din[0];
        eAdd = isWr && off == 4 && din[0];
        eClr = isWr && off == 5 && din[0];

        nRaddr = eRaddr;
        if (clrNow) nRaddr = 0;
        else if (isRd && off == 6) nRaddr = (eRaddr + 1) % 8;

        rise  = done && !mDonePrev;
        nPend = mPend;
        if (rise) nPend = 1;
        else if ((isWr && off == 8 && din[0]) || clrNow) nPend = 0;

        eInt = mIntEn && mPend;
        if (isWr && off == 2) mIntEn = din[0];
`ifdef ACCEL_SLAVE_ERRCNT_EN
        if (clrNow) mErr = 0;
        else if (drop && mErr < 255) mErr = mErr + 1;
`endif
        eRaddr    = nRaddr;
        mPend     = nPend;
        mDonePrev = done;

        @(posedge clk);
        #1;
        checkAll(tag);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".s_dout"},      s_dout,      0);
        checkOutput({tag, ".mc_we"},       mc_we,       0);
        checkOutput({tag, ".mc_wdata"},    mc_wdata,    0);
        checkOutput({tag, ".mp_we"},       mp_we,       0);
        checkOutput({tag, ".mp_wdata"},    mp_wdata,    0);
        checkOutput({tag, ".mul_start"},   mul_start,   0);
        checkOutput({tag, ".add_start"},   add_start,   0);
        checkOutput({tag, ".op_clear"},    op_clear,    0);
        checkOutput({tag, ".r_addr"},      r_addr,      0);
        checkOutput({tag, ".m_interrupt"}, m_interrupt, 0);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) resBuf[i] = $urandom;
        reset = 1'b1;
        s_sel = 0; s_wr = 0; s_addr = 0; s_din = 0;
        mc_count = 0; mp_count = 0; op_done = 0;
        modelReset();
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b0;

        // Nine RESULT reads walk r_addr 0..7 and wrap to 0.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1, 0, 6, 0, 0, 0, 0, "resRead");
            checkOutput("resReadAddr", r_addr, (i + 1) % 8);
            checkOutput("resReadData", s_dout, resBuf[i % 8]);
        end

        applyStimulus(1, 1, 0, 32'h1234_5678, 3, 0, 0, "mcWrite");
        checkOutput("mcWeAccepted", mc_we, 1);
        checkOutput("mcWdataAccepted", mc_wdata, 32'h1234_5678);
        applyStimulus(0, 0, 0, 0, 3, 0, 0, "idle");
        checkOutput("mcWeOneCycle", mc_we, 0);
        applyStimulus(1, 1, 0, 32'hDEAD_BEEF, 8, 0, 0, "mcFull");
        checkOutput("mcWeFull", mc_we, 0);
        applyStimulus(1, 0, 9, 0, 8, 0, 0, "errRead");
`ifdef ACCEL_SLAVE_ERRCNT_EN
        checkOutput("errCntOne", s_dout, 1);
`else
        checkOutput("errCntAbsent", s_dout, 0);
`endif

        applyStimulus(1, 1, 3, 1, 0, 0, 0, "mulStart");
        checkOutput("mulPulseHigh", mul_start, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "idle");
        checkOutput("mulPulseLow", mul_start, 0);
        applyStimulus(1, 1, 3, 32'hFFFF_FFFE, 0, 0, 0, "mulZero");
        checkOutput("mulNoPulse", mul_start, 0);

        applyStimulus(1, 1, 2, 1, 0, 0, 0, "intEn");
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "doneRise");
        checkOutput("intAfterOne", m_interrupt, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "doneHold");
        checkOutput("intAfterTwo", m_interrupt, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, "doneLow");
        applyStimulus(1, 1, 8, 1, 0, 0, 1, "w1cWithEdge");
        applyStimulus(1, 0, 7, 0, 0, 0, 1, "statRead");
        checkOutput("pendSurvivesW1c", s_dout[8], 1);

        // r_addr is 1 here; four reads bring it to 5 before the clear.
        for (int i = 0; i < 4; i++) applyStimulus(1, 0, 6, 0, 0, 0, 1, "advance");
        checkOutput("rAddrBeforeClr", r_addr, 5);
        applyStimulus(1, 1, 5, 1, 0, 0, 1, "clrWrite");
        checkOutput("clrPulse", op_clear, 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 1, "clrDone");
        checkOutput("rAddrAfterClr", r_addr, 0);
        applyStimulus(1, 0, 7, 0, 0, 0, 1, "statAfterClr");
        checkOutput("pendAfterClr", s_dout[8], 0);
        applyStimulus(1, 0, 2, 0, 0, 0, 1, "intEnAfterClr");
        checkOutput("intEnKept", s_dout, 1);

        begin
            bit done = 0;
            for (int c = 0; c < 3000; c++) begin
                bit   sel, wr;
                int   off;
                logic [31:0] din;
                if ($urandom_range(0, 7) == 0) done = !done;
                sel = $urandom_range(0, 9) < 7;
                wr  = $urandom_range(0, 1) == 1;
                off = int'($urandom_range(0, 18)) - 4;
                din = $urandom;
                applyStimulus(sel, wr, off, din, $urandom_range(0, 8), $urandom_range(0, 8), done, "rand");
                if (c == 1500) begin
                    applyStimulus(1, 1, 3, 1, 2, 2, done, "preReset");
                    #2 reset = 1'b1;
                    #1 checkAllZero("midReset");
                    @(negedge clk);
                    reset = 1'b0;
                    modelReset();
                    done = 0;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
